// File: rtl/switch_fifo.sv
// switch_fifo: 2x2 ring routing switch with a FIFO on each output.
// Each beat goes to the output with the lowest cost, which is the downstream
// latency plus the local FIFO occupancy. The cost advertised upstream is
// registered, so the latency/ready path does not close a combinational loop
// around the ring.
module switch_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LAT_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                in_valid,
    input  logic [2*DATA_WIDTH-1:0]   in_data,
    output logic [1:0]                in_ready,
    output logic [LAT_WIDTH-1:0]      in_latency,
    output logic [1:0]                out_valid,
    output logic [2*DATA_WIDTH-1:0]   out_data,
    input  logic [1:0]                out_ready,
    input  logic [2*LAT_WIDTH-1:0]    out_latency
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam int unsigned CW = LAT_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem    [2][FIFO_DEPTH];
    logic [OW-1:0]         occ    [2];
    logic [PW-1:0]         wr_ptr [2];
    logic [PW-1:0]         rd_ptr [2];
    logic [CW-1:0]         sum    [2];
    logic [LAT_WIDTH-1:0]  cost   [2];
    logic [DATA_WIDTH-1:0] wdata  [2];

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] tgt;      // tgt[i]: output targeted by input i
    logic [1:0] accept;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       best;

    // FIFO status flags and per-output saturating cost
    always_comb begin
        full  = '0;
        empty = '0;
        for (int k = 0; k < 2; k++) begin
            full[k]  = (occ[k] == OW'(FIFO_DEPTH));
            empty[k] = (occ[k] == '0);
            sum[k]   = CW'(out_latency[k*LAT_WIDTH +: LAT_WIDTH]) + CW'(occ[k]);
            cost[k]  = sum[k][LAT_WIDTH] ? '1 : sum[k][LAT_WIDTH-1:0];
        end
        // Ties go to output 1
        best = (cost[1] > cost[0]) ? 1'b0 : 1'b1;
    end

    // Routing: crossed when both or neither input is valid, cheapest output otherwise
    always_comb begin
        tgt = 2'b01;
        if (in_valid == 2'b01) begin
            tgt[0] = best;
        end else if (in_valid == 2'b10) begin
            tgt[1] = best;
        end
        in_ready = '0;
        for (int i = 0; i < 2; i++) begin
            in_ready[i] = ~full[tgt[i]];
        end
        accept = in_valid & in_ready;
    end

    // Push/pop decode and write-data select per output
    always_comb begin
        sel0 = '0;
        sel1 = '0;
        push = '0;
        pop  = '0;
        for (int k = 0; k < 2; k++) begin
            sel0[k]  = accept[0] && (tgt[0] == 1'(k));
            sel1[k]  = accept[1] && (tgt[1] == 1'(k));
            push[k]  = sel0[k] | sel1[k];
            pop[k]   = ~empty[k] & out_ready[k];
            wdata[k] = sel0[k] ? in_data[DATA_WIDTH-1:0]
                               : in_data[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    // Output side: head of each FIFO, valid whenever non-empty
    always_comb begin
        out_valid = ~empty;
        out_data  = '0;
        for (int k = 0; k < 2; k++) begin
            out_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][rd_ptr[k]];
        end
    end

    // FIFO storage, intentionally not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (push[k]) begin
                mem[k][wr_ptr[k]] <= wdata[k];
            end
        end
    end

    // Pointers and occupancy; reset discards all buffered beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                occ[k]    <= '0;
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (push[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PW'(1);
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PW'(1);
                end
                case ({push[k], pop[k]})
                    2'b10:   occ[k] <= occ[k] + OW'(1);
                    2'b01:   occ[k] <= occ[k] - OW'(1);
                    default: occ[k] <= occ[k];
                endcase
            end
        end
    end

    // Advertised upstream latency: minimum cost, one cycle behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_latency <= '0;
        end else begin
            in_latency <= (cost[0] < cost[1]) ? cost[0] : cost[1];
        end
    end

endmodule

// File: tb/tb_switch_fifo.sv
// Directed self-checking bench for switch_fifo (DATA_WIDTH=16, LAT_WIDTH=8, FIFO_DEPTH=4).
module tb_switch_fifo;

    logic        clk;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [31:0] in_data;
    logic [1:0]  in_ready;
    logic [7:0]  in_latency;
    logic [1:0]  out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_ready;
    logic [15:0] out_latency;

    int n_checks = 0;
    int n_fail   = 0;

    switch_fifo #(
        .DATA_WIDTH (16),
        .LAT_WIDTH  (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .in_latency  (in_latency),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_latency (out_latency)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 2'b00;
        in_data     = '0;
        out_ready   = 2'b00;
        out_latency = {8'd3, 8'd3};
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h3);
        chk("rst_in_latency", 32'(in_latency), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single input, tie between outputs goes to output 1
        chk("tie_lat_before", 32'(in_latency), 32'd3);
        in_valid = 2'b01;
        in_data  = {16'h0000, 16'h00A5};
        #1;
        chk("tie_in_ready", 32'(in_ready), 32'h3);
        tick();
        in_valid = 2'b00;
        chk("tie_out_valid", 32'(out_valid), 32'h2);
        chk("tie_out_data1", 32'(out_data[31:16]), 32'h00A5);
        chk("tie_lat_after_push", 32'(in_latency), 32'd3);
        out_ready = 2'b10;
        tick();
        out_ready = 2'b00;
        chk("tie_lat_stored", 32'(in_latency), 32'd3);
        chk("tie_drained", 32'(out_valid), 32'h0);

        // Occupancy-driven routing: 4 beats on input 0 alternate 1,0,1,0
        out_latency = {8'd0, 8'd0};
        for (int n = 0; n < 4; n++) begin
            in_valid = 2'b01;
            in_data  = {16'h0000, 16'(16'h0010 + n)};
            #1;
            chk("occ_in_ready0", 32'(in_ready[0]), 32'h1);
            tick();
        end
        in_valid = 2'b00;
        chk("occ_out_valid", 32'(out_valid), 32'h3);
        chk("occ_head0", 32'(out_data[15:0]), 32'h0011);
        chk("occ_head1", 32'(out_data[31:16]), 32'h0010);
        chk("occ_lat_1", 32'(in_latency), 32'd1);
        tick();
        chk("occ_lat_2", 32'(in_latency), 32'd2);
        out_ready = 2'b11;
        tick();
        chk("occ_next0", 32'(out_data[15:0]), 32'h0013);
        chk("occ_next1", 32'(out_data[31:16]), 32'h0012);
        tick();
        chk("occ_empty", 32'(out_valid), 32'h0);

        // Crossed routing with output 0 backpressured
        out_ready = 2'b10;
        for (int c = 0; c < 6; c++) begin
            in_valid = 2'b11;
            in_data  = {16'(16'h0200 + ((c < 4) ? c : 4)), 16'(16'h0100 + c)};
            #1;
            chk("x_in_ready", 32'(in_ready), (c < 4) ? 32'h3 : 32'h1);
            tick();
            chk("x_out_valid1", 32'(out_valid[1]), 32'h1);
            chk("x_out_data1", 32'(out_data[31:16]), 32'(16'h0100 + c));
        end
        chk("x_full_head0", 32'(out_data[15:0]), 32'h0200);

        // Full boundary: pop and push on full FIFO 0 in the same cycle
        out_ready = 2'b01;
        in_data   = {16'h0204, 16'h0106};
        #1;
        chk("fb_refused", 32'(in_ready), 32'h1);
        tick();
        chk("fb_head0_a", 32'(out_data[15:0]), 32'h0201);
        in_data = {16'h0204, 16'h0107};
        #1;
        chk("fb_accepted", 32'(in_ready), 32'h3);
        tick();
        in_valid  = 2'b00;
        out_ready = 2'b11;
        chk("fb_head0_b", 32'(out_data[15:0]), 32'h0202);
        chk("fb_head1_b", 32'(out_data[31:16]), 32'h0105);
        tick();
        chk("fb_head0_c", 32'(out_data[15:0]), 32'h0203);
        chk("fb_head1_c", 32'(out_data[31:16]), 32'h0106);
        tick();
        chk("fb_head0_d", 32'(out_data[15:0]), 32'h0204);
        chk("fb_head1_d", 32'(out_data[31:16]), 32'h0107);
        tick();
        chk("fb_empty", 32'(out_valid), 32'h0);

        // Reset asserted while traffic is active
        out_ready = 2'b00;
        in_valid  = 2'b11;
        in_data   = {16'h0300, 16'h0301};
        tick();
        chk("mr_loaded", 32'(out_valid), 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_in_ready", 32'(in_ready), 32'h3);
        chk("mr_in_latency", 32'(in_latency), 32'h0);
        tick();
        in_valid = 2'b00;
        rst_n    = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("mr_idle", 32'(out_valid), 32'h0);
        end

        // Saturation: both costs clamp at 255
        out_latency = {8'd255, 8'd255};
        in_valid    = 2'b11;
        in_data     = {16'h0400, 16'h0401};
        tick();
        in_valid = 2'b00;
        chk("sat_lat_empty", 32'(in_latency), 32'd255);
        chk("sat_stored", 32'(out_valid), 32'h3);
        tick();
        chk("sat_lat_clamped", 32'(in_latency), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
